ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline, downstream of the ID/EX register and the forwarding unit.
//  - Resolves ALU operands from the forwarding selects.
//  - Performs ALU ops, including an iterative 32-cycle multiply.
//  - Owns the EX/MEM pipeline register. Its EXMEM_* outputs feed the MEM stage and the forwarding unit.
//  - Raises ex_busy_o so the hazard unit freezes IF/ID/ID-EX while a multiply runs.
// PARAMETERS
//  DATA_W    32  datapath width
//  MUL_ITER  32  shift-add iterations per multiply (= DATA_W)
// PORTS
//  clk_i            in   1   clock; all state on rising edge
//  rst_n_i          in   1   asynchronous, active-low reset
//  stall_i          in   1   downstream stall; EX/MEM register holds its value
//  flush_i          in   1   EX/MEM loads a bubble; aborts any multiply
//  IDEX_valid_i     in   1   ID/EX holds a real instruction
//  IDEX_rs_data_i   in   32  register-file rs value
//  IDEX_rt_data_i   in   32  register-file rt value
//  IDEX_imm_i       in   32  sign-extended immediate
//  IDEX_alusrc_i    in   1   1: operand2 = imm, 0: operand2 = forwarded rt
//  IDEX_aluop_i     in   4   ALU opcode (package alu_op_t)
//  IDEX_Rd_i        in   5   resolved destination register
//  IDEX_rw_i        in   1   register write enable
//  IDEX_memread_i   in   1   load
//  IDEX_memwrite_i  in   1   store
//  IDEX_memtoreg_i  in   1   writeback from memory
//  ALUdata1_sel_i   in   2   rs forward select: 10 EX/MEM, 01 MEM/WB, 00 or 11 register file
//  ALUdata2_sel_i   in   2   rt forward select, same encoding
//  MEMWB_data_i     in   32  MEM/WB writeback value
//  EXMEM_valid_o    out  1   EX/MEM holds a real instruction
//  EXMEM_alu_o      out  32  ALU result / memory address
//  EXMEM_wdata_o    out  32  forwarded rt value (store data)
//  EXMEM_Rd_o       out  5   destination register
//  EXMEM_rw_o       out  1   register write enable
//  EXMEM_memread_o  out  1   load
//  EXMEM_memwrite_o out  1   store
//  EXMEM_memtoreg_o out  1   writeback from memory
//  ex_busy_o        out  1   multiply in progress; hold upstream
// BEHAVIOUR
//  - Reset: all EXMEM_* outputs 0; multiplier FSM = IDLE; ex_busy_o = 0.
//  - Operand mux (combinational):
//    - 10 selects EXMEM_alu_o; 01 selects MEMWB_data_i; otherwise register data.
//    - op2 = alusrc ? imm : forwarded rt.
//  - ALU ops (alu_op_t):
//    - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5 (signed, result 0 or 1).
//    - SLL=6, SRL=7: shift op1 by op2[4:0].
//    - MUL=8: low 32 bits of the unsigned product, multi-cycle.
//    - Opcodes 9-15 give result 0.
//    - Wrap modulo 2^32; no overflow trap.
//  - Single-cycle ops: result registered into EX/MEM at the next edge (1-cycle latency).
//  - Multiplier FSM, IDLE -> RUN -> DONE -> IDLE:
//    - IDLE: a valid MUL in ID/EX with no flush latches op1/op2, clears the accumulator, sets count=0, moves to RUN.
//      ex_busy_o = 1 combinationally in that same cycle.
//    - RUN: one shift-add per cycle; leaves for DONE when count == MUL_ITER-1. ex_busy_o = 1.
//    - DONE: ex_busy_o = 0; product drives the EX/MEM D input; returns to IDLE when EX/MEM loads (no stall).
//    - A MUL occupies EX for MUL_ITER+1 = 33 cycles.
//    - Operands are latched at start, so later forwarding-source changes do not affect the product.
//  - While ex_busy_o = 1, EX/MEM loads a bubble each cycle so older instructions drain:
//    - valid, rw, memread and memwrite are 0; data fields are don't-care but held.
//  - Priority: reset > flush_i > stall_i > normal load.
//    - flush_i: EX/MEM loads a bubble; FSM returns to IDLE from any state; ex_busy_o drops the next cycle.
//    - stall_i: EX/MEM holds all fields. An active multiply keeps counting. DONE waits until stall_i drops.
//    - stall_i and ex_busy_o together: EX/MEM holds; no bubble is inserted.
//  - IDEX_valid_i = 0: EX/MEM loads a bubble; a MUL opcode does not start the FSM.
//  - Reset during a multiply: FSM to IDLE immediately; product discarded.
// STRUCTURE
//  - Shared package mips_pkg:
//    - alu_op_t enum.
//    - FWD_EXMEM=2'b10, FWD_MEMWB=2'b01, FWD_REG=2'b00.
//    - DATA_W.
//  - Sub-module mul_iter: FSM, counter, operand/accumulator registers; start/flush/hold inputs; busy/done/product outputs.
//  - Operand mux, ALU and the EX/MEM register live in ex_stage.
// TESTING
//  1. ADD, rs=5, rt=7, sel 00/00 -> next cycle EXMEM_alu_o=12, EXMEM_rw_o=1, EXMEM_valid_o=1.
//  2. Back-to-back: ADD r3=1+2, then SUB r4=r3-1 with ALUdata1_sel=10 -> second result 2.
//     Repeat with sel=01 and MEMWB_data_i=9 -> 8.
//  3. MUL 0xFFFF_FFFF*3 -> ex_busy_o high 32 cycles; EXMEM_alu_o=0xFFFF_FFFD on cycle 33.
//     Intervening EX/MEM loads are bubbles (rw=0).
//  4. MUL start, flush_i at cycle 10 -> bubble loaded; ex_busy_o=0 next cycle.
//     A new ADD then completes in 1 cycle.
//  5. stall_i held 3 cycles after ADD result=4 -> EXMEM outputs unchanged.
//     stall_i in DONE delays capture until release.
//  6. Assert rst_n_i low mid-multiply (asynchronous) -> all outputs 0 immediately; ex_busy_o=0.
//     SLT -1<1 after reset -> 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS execute stage.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MUL_ITER = DATA_W;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned FWD_W    = 2;

  // Forwarding select encodings; 2'b11 also falls back to the register file
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
  localparam logic [FWD_W-1:0] FWD_REG   = 2'b00;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_MUL = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // EX/MEM pipeline register payload
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
    logic              rw;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
  } exmem_t;

  // Pick an operand source from a forwarding select
  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [FWD_W-1:0]  sel,
    input logic [DATA_W-1:0] reg_v,
    input logic [DATA_W-1:0] exmem_v,
    input logic [DATA_W-1:0] memwb_v
  );
    logic [DATA_W-1:0] res;
    case (sel)
      FWD_EXMEM: res = exmem_v;
      FWD_MEMWB: res = memwb_v;
      FWD_REG:   res = reg_v;
      default:   res = reg_v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding inputs and EX/MEM outputs of the execute stage.
interface ex_stage_if;
  import mips_pkg::*;

  logic                IDEX_valid_i;
  logic [DATA_W-1:0]   IDEX_rs_data_i;
  logic [DATA_W-1:0]   IDEX_rt_data_i;
  logic [DATA_W-1:0]   IDEX_imm_i;
  logic                IDEX_alusrc_i;
  logic [ALUOP_W-1:0]  IDEX_aluop_i;
  logic [REG_W-1:0]    IDEX_Rd_i;
  logic                IDEX_rw_i;
  logic                IDEX_memread_i;
  logic                IDEX_memwrite_i;
  logic                IDEX_memtoreg_i;
  logic [FWD_W-1:0]    ALUdata1_sel_i;
  logic [FWD_W-1:0]    ALUdata2_sel_i;
  logic [DATA_W-1:0]   MEMWB_data_i;

  logic                EXMEM_valid_o;
  logic [DATA_W-1:0]   EXMEM_alu_o;
  logic [DATA_W-1:0]   EXMEM_wdata_o;
  logic [REG_W-1:0]    EXMEM_Rd_o;
  logic                EXMEM_rw_o;
  logic                EXMEM_memread_o;
  logic                EXMEM_memwrite_o;
  logic                EXMEM_memtoreg_o;
  logic                ex_busy_o;

  modport master (
    output IDEX_valid_i, IDEX_rs_data_i, IDEX_rt_data_i, IDEX_imm_i,
           IDEX_alusrc_i, IDEX_aluop_i, IDEX_Rd_i, IDEX_rw_i,
           IDEX_memread_i, IDEX_memwrite_i, IDEX_memtoreg_i,
           ALUdata1_sel_i, ALUdata2_sel_i, MEMWB_data_i,
    input  EXMEM_valid_o, EXMEM_alu_o, EXMEM_wdata_o, EXMEM_Rd_o,
           EXMEM_rw_o, EXMEM_memread_o, EXMEM_memwrite_o, EXMEM_memtoreg_o,
           ex_busy_o
  );

  modport slave (
    input  IDEX_valid_i, IDEX_rs_data_i, IDEX_rt_data_i, IDEX_imm_i,
           IDEX_alusrc_i, IDEX_aluop_i, IDEX_Rd_i, IDEX_rw_i,
           IDEX_memread_i, IDEX_memwrite_i, IDEX_memtoreg_i,
           ALUdata1_sel_i, ALUdata2_sel_i, MEMWB_data_i,
    output EXMEM_valid_o, EXMEM_alu_o, EXMEM_wdata_o, EXMEM_Rd_o,
           EXMEM_rw_o, EXMEM_memread_o, EXMEM_memwrite_o, EXMEM_memtoreg_o,
           ex_busy_o
  );

endinterface

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W bits kept.
module mul_iter
  import mips_pkg::*;
#(
  parameter int unsigned ITER = MUL_ITER
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start,
  input  logic              flush,
  input  logic              hold,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  mul_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] acc;

  assign product = acc;

  // Multiplier FSM with operand latch, counter and registered busy/done flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (flush) begin
      state <= MUL_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mplier <= op_a;
            mcand  <= op_b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          // Product stays on the output until EX/MEM actually captures it
          if (!hold) begin
            done  <= 1'b0;
            state <= MUL_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= MUL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative multiply and the EX/MEM register.
module ex_stage
  import mips_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       stall_i,
  input  logic       flush_i,
  ex_stage_if.slave  bus
);

  alu_op_t           aluop;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] ex_res;
  logic [DATA_W-1:0] mul_product;
  logic              is_mul;
  logic              mul_start_c;
  logic              mul_busy;
  logic              mul_done;
  logic              ex_busy_c;
  exmem_t            exmem_q;

  assign aluop = alu_op_t'(bus.IDEX_aluop_i);

  // Resolve operands from the forwarding selects
  always_comb begin
    fwd_a = fwd_mux(bus.ALUdata1_sel_i, bus.IDEX_rs_data_i, exmem_q.alu, bus.MEMWB_data_i);
    fwd_b = fwd_mux(bus.ALUdata2_sel_i, bus.IDEX_rt_data_i, exmem_q.alu, bus.MEMWB_data_i);
    op_a  = fwd_a;
    op_b  = bus.IDEX_alusrc_i ? bus.IDEX_imm_i : fwd_b;
  end

  // Single-cycle ALU; MUL and unused opcodes give 0 here
  always_comb begin
    alu_res = '0;
    case (aluop)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLT: alu_res = DATA_W'($signed(op_a) < $signed(op_b));
      ALU_SLL: alu_res = op_a << op_b[SHAMT_W-1:0];
      ALU_SRL: alu_res = op_a >> op_b[SHAMT_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // A multiply may only start from idle; no start is seen while reset is held
  assign is_mul      = bus.IDEX_valid_i && (aluop == ALU_MUL);
  assign mul_start_c = rst_n_i && is_mul && !flush_i && !mul_busy && !mul_done;
  assign ex_busy_c   = mul_start_c || mul_busy;
  assign ex_res      = mul_done ? mul_product : alu_res;

  mul_iter #(
    .ITER (MUL_ITER)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start   (mul_start_c),
    .flush   (flush_i),
    .hold    (stall_i),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // EX/MEM register: flush > stall > bubble (busy or invalid) > load
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      exmem_q <= '0;
    end else if (flush_i || !stall_i) begin
      if (flush_i || ex_busy_c || !bus.IDEX_valid_i) begin
        exmem_q.valid    <= 1'b0;
        exmem_q.rw       <= 1'b0;
        exmem_q.memread  <= 1'b0;
        exmem_q.memwrite <= 1'b0;
      end else begin
        exmem_q.valid    <= 1'b1;
        exmem_q.alu      <= ex_res;
        exmem_q.wdata    <= fwd_b;
        exmem_q.rd       <= bus.IDEX_Rd_i;
        exmem_q.rw       <= bus.IDEX_rw_i;
        exmem_q.memread  <= bus.IDEX_memread_i;
        exmem_q.memwrite <= bus.IDEX_memwrite_i;
        exmem_q.memtoreg <= bus.IDEX_memtoreg_i;
      end
    end
  end

  assign bus.EXMEM_valid_o    = exmem_q.valid;
  assign bus.EXMEM_alu_o      = exmem_q.alu;
  assign bus.EXMEM_wdata_o    = exmem_q.wdata;
  assign bus.EXMEM_Rd_o       = exmem_q.rd;
  assign bus.EXMEM_rw_o       = exmem_q.rw;
  assign bus.EXMEM_memread_o  = exmem_q.memread;
  assign bus.EXMEM_memwrite_o = exmem_q.memwrite;
  assign bus.EXMEM_memtoreg_o = exmem_q.memtoreg;
  assign bus.ex_busy_o        = ex_busy_c;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, multiply timing, flush/stall/reset.
module tb_ex_stage;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  logic stall;
  logic flush;
  int   n_chk;
  int   n_pass;
  int   run;
  int   bad;

  ex_stage_if bus();

  ex_stage dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .stall_i (stall),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.IDEX_valid_i    = 1'b0;
    bus.IDEX_rs_data_i  = '0;
    bus.IDEX_rt_data_i  = '0;
    bus.IDEX_imm_i      = '0;
    bus.IDEX_alusrc_i   = 1'b0;
    bus.IDEX_aluop_i    = ALU_ADD;
    bus.IDEX_Rd_i       = '0;
    bus.IDEX_rw_i       = 1'b0;
    bus.IDEX_memread_i  = 1'b0;
    bus.IDEX_memwrite_i = 1'b0;
    bus.IDEX_memtoreg_i = 1'b0;
    bus.ALUdata1_sel_i  = FWD_REG;
    bus.ALUdata2_sel_i  = FWD_REG;
    bus.MEMWB_data_i    = '0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    set_idle();
    bus.IDEX_valid_i   = 1'b1;
    bus.IDEX_aluop_i   = op;
    bus.IDEX_rs_data_i = a;
    bus.IDEX_rt_data_i = b;
    bus.IDEX_Rd_i      = 5'd1;
    bus.IDEX_rw_i      = 1'b1;
  endtask

  task automatic run_alu(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    set_op(op, a, b);
    tick();
    check_eq(tag, bus.EXMEM_alu_o, exp);
  endtask

  // Counts busy cycles after the start edge; operands are scrambled meanwhile
  task automatic wait_mul(output int run_n, output int bad_n);
    run_n = 0;
    bad_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.ex_busy_o) break;
      run_n++;
      if (bus.EXMEM_valid_o || bus.EXMEM_rw_o) bad_n++;
      bus.IDEX_rs_data_i = 32'(i);
      bus.IDEX_rt_data_i = 32'(i + 1);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    set_idle();

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(bus.EXMEM_valid_o), 32'd0);
    check_eq("rst_alu", bus.EXMEM_alu_o, 32'd0);
    check_eq("rst_rw", 32'(bus.EXMEM_rw_o), 32'd0);
    check_eq("rst_busy", 32'(bus.ex_busy_o), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Basic ADD
    set_op(ALU_ADD, 32'd5, 32'd7);
    bus.IDEX_Rd_i = 5'd3;
    tick();
    check_eq("add_alu", bus.EXMEM_alu_o, 32'd12);
    check_eq("add_rw", 32'(bus.EXMEM_rw_o), 32'd1);
    check_eq("add_valid", 32'(bus.EXMEM_valid_o), 32'd1);
    check_eq("add_rd", 32'(bus.EXMEM_Rd_o), 32'd3);

    // Back-to-back forwarding
    run_alu("fwd_base", ALU_ADD, 32'd1, 32'd2, 32'd3);
    set_op(ALU_SUB, 32'd100, 32'd0);
    bus.ALUdata1_sel_i = FWD_EXMEM;
    bus.IDEX_alusrc_i  = 1'b1;
    bus.IDEX_imm_i     = 32'd1;
    tick();
    check_eq("fwd_exmem", bus.EXMEM_alu_o, 32'd2);
    set_op(ALU_SUB, 32'd100, 32'd0);
    bus.ALUdata1_sel_i = FWD_MEMWB;
    bus.MEMWB_data_i   = 32'd9;
    bus.IDEX_alusrc_i  = 1'b1;
    bus.IDEX_imm_i     = 32'd1;
    tick();
    check_eq("fwd_memwb", bus.EXMEM_alu_o, 32'd8);

    // Store: address from imm, store data forwarded from EX/MEM
    set_op(ALU_ADD, 32'd16, 32'd0);
    bus.IDEX_alusrc_i   = 1'b1;
    bus.IDEX_imm_i      = 32'd4;
    bus.ALUdata2_sel_i  = FWD_EXMEM;
    bus.IDEX_rw_i       = 1'b0;
    bus.IDEX_memwrite_i = 1'b1;
    tick();
    check_eq("st_addr", bus.EXMEM_alu_o, 32'd20);
    check_eq("st_wdata", bus.EXMEM_wdata_o, 32'd8);
    check_eq("st_memwrite", 32'(bus.EXMEM_memwrite_o), 32'd1);

    // Invalid MUL: bubble, no start
    set_op(ALU_MUL, 32'd3, 32'd3);
    bus.IDEX_valid_i = 1'b0;
    #1;
    check_eq("inv_busy", 32'(bus.ex_busy_o), 32'd0);
    tick();
    check_eq("inv_valid", 32'(bus.EXMEM_valid_o), 32'd0);
    check_eq("inv_busy2", 32'(bus.ex_busy_o), 32'd0);

    // ALU op table
    run_alu("and", ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
    run_alu("or", ALU_OR, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    run_alu("xor", ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    run_alu("sll_mask", ALU_SLL, 32'd1, 32'h0000_0023, 32'd8);
    run_alu("srl", ALU_SRL, 32'h8000_0000, 32'd31, 32'd1);
    run_alu("slt_neg", ALU_SLT, 32'h8000_0000, 32'd1, 32'd1);
    run_alu("slt_false", ALU_SLT, 32'd5, 32'd3, 32'd0);
    run_alu("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_alu("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
    run_alu("op9", 4'd9, 32'd5, 32'd7, 32'd0);
    run_alu("op15", 4'd15, 32'd5, 32'd7, 32'd0);

    // Full multiply
    set_op(ALU_MUL, 32'hFFFF_FFFF, 32'd3);
    bus.IDEX_Rd_i = 5'd7;
    #1;
    check_eq("mul_start_busy", 32'(bus.ex_busy_o), 32'd1);
    wait_mul(run, bad);
    check_eq("mul_run_cycles", 32'(run), 32'd32);
    check_eq("mul_bubbles", 32'(bad), 32'd0);
    check_eq("mul_done_pending", 32'(bus.EXMEM_valid_o), 32'd0);
    tick();
    check_eq("mul_product", bus.EXMEM_alu_o, 32'hFFFF_FFFD);
    check_eq("mul_valid", 32'(bus.EXMEM_valid_o), 32'd1);
    check_eq("mul_rw", 32'(bus.EXMEM_rw_o), 32'd1);
    check_eq("mul_rd", 32'(bus.EXMEM_Rd_o), 32'd7);
    set_idle();

    // Flush mid-multiply
    set_op(ALU_MUL, 32'd6, 32'd7);
    repeat (10) tick();
    check_eq("flush_pre_busy", 32'(bus.ex_busy_o), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_op(ALU_ADD, 32'd2, 32'd2);
    #1;
    check_eq("flush_busy", 32'(bus.ex_busy_o), 32'd0);
    check_eq("flush_bubble", 32'(bus.EXMEM_valid_o), 32'd0);
    tick();
    check_eq("add_after_flush", bus.EXMEM_alu_o, 32'd4);
    check_eq("add_after_flush_v", 32'(bus.EXMEM_valid_o), 32'd1);

    // Stall holds EX/MEM
    stall = 1'b1;
    set_op(ALU_ADD, 32'd100, 32'd100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_hold", bus.EXMEM_alu_o, 32'd4);
    end
    stall = 1'b0;

    // Stall in DONE delays capture
    set_op(ALU_MUL, 32'd6, 32'd7);
    wait_mul(run, bad);
    check_eq("mul2_run_cycles", 32'(run), 32'd32);
    stall = 1'b1;
    tick();
    check_eq("done_stall_v", 32'(bus.EXMEM_valid_o), 32'd0);
    check_eq("done_stall_alu", bus.EXMEM_alu_o, 32'd4);
    tick();
    check_eq("done_stall_v2", 32'(bus.EXMEM_valid_o), 32'd0);
    stall = 1'b0;
    tick();
    check_eq("done_release", bus.EXMEM_alu_o, 32'd42);
    check_eq("done_release_v", 32'(bus.EXMEM_valid_o), 32'd1);

    // Stall together with busy: hold, no bubble
    set_op(ALU_MUL, 32'hFFFF_FFFF, 32'd3);
    stall = 1'b1;
    tick();
    tick();
    check_eq("stall_busy_hold", 32'(bus.EXMEM_valid_o), 32'd1);
    check_eq("stall_busy_run", 32'(bus.ex_busy_o), 32'd1);
    stall = 1'b0;
    repeat (3) tick();
    check_eq("busy_bubble", 32'(bus.EXMEM_valid_o), 32'd0);

    // Asynchronous reset mid-multiply
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_alu", bus.EXMEM_alu_o, 32'd0);
    check_eq("arst_rw", 32'(bus.EXMEM_rw_o), 32'd0);
    check_eq("arst_busy", 32'(bus.ex_busy_o), 32'd0);
    set_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_eq("slt_after_rst", bus.EXMEM_alu_o, 32'd1);
    check_eq("slt_after_rst_v", 32'(bus.EXMEM_valid_o), 32'd1);
    check_eq("slt_after_rst_busy", 32'(bus.ex_busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
